// File: rtl/door_lock_pkg.sv
// Shared types, default parameters and width helpers for the door access controller.
package door_lock_pkg;

  typedef enum logic [1:0] {
    ARMED,
    OPEN,
    LOCKOUT,
    ALARM
  } door_state_t;

  localparam int DEF_MAX_FAILS      = 3;
  localparam int DEF_MAX_LOCKOUTS   = 2;
  localparam int DEF_OPEN_CYCLES    = 50;
  localparam int DEF_LOCKOUT_CYCLES = 100;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold 0..n inclusive (saturating counters).
  function automatic int sat_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Bits for a down-counter loaded with at most n-1; never narrower than 1.
  function automatic int timer_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/door_timer.sv
// Loadable down-counter shared by the OPEN and LOCKOUT dwell periods.
module door_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  // Load wins over counting; the counter parks at zero rather than wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/door_access_ctrl.sv
// Sequences the serial code detector: gates keypad bits, times the open door,
// counts failed attempts, enforces lockouts and latches an intrusion alarm.
module door_access_ctrl
  import door_lock_pkg::*;
#(
  parameter int MAX_FAILS      = DEF_MAX_FAILS,
  parameter int MAX_LOCKOUTS   = DEF_MAX_LOCKOUTS,
  parameter int OPEN_CYCLES    = DEF_OPEN_CYCLES,
  parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             key_in,
  input  logic                             det_unlock,
  input  logic                             det_error,
  input  logic                             admin_clr,
  output logic                             det_in,
  output logic                             det_rst,
  output logic                             lock_open,
  output logic                             lockout,
  output logic                             alarm,
  output logic [$clog2(MAX_FAILS+1)-1:0]   fail_cnt
);

  localparam int FAIL_W = $clog2(MAX_FAILS + 1);
  localparam int LOCK_W = sat_width(MAX_LOCKOUTS);
  localparam int TMR_W  = timer_width(max_int(OPEN_CYCLES, LOCKOUT_CYCLES));

  localparam logic [FAIL_W-1:0] FAIL_LIMIT   = FAIL_W'(MAX_FAILS);
  localparam logic [LOCK_W-1:0] LOCK_LIMIT   = LOCK_W'(MAX_LOCKOUTS);
  localparam logic [TMR_W-1:0]  OPEN_LOAD    = TMR_W'(OPEN_CYCLES - 1);
  localparam logic [TMR_W-1:0]  LOCKOUT_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);

  door_state_t       state;
  logic [LOCK_W-1:0] lock_cnt;
  logic [FAIL_W-1:0] fail_next;
  logic [LOCK_W-1:0] lock_next;
  logic              trip;
  logic              to_alarm;
  logic              tmr_load;
  logic [TMR_W-1:0]  tmr_val;
  logic              tmr_en;
  logic              tmr_done;

  // Saturating next counts and the timer load decision for the coming edge.
  always_comb begin
    fail_next = (fail_cnt == FAIL_LIMIT) ? fail_cnt : fail_cnt + FAIL_W'(1);
    lock_next = (lock_cnt == LOCK_LIMIT) ? lock_cnt : lock_cnt + LOCK_W'(1);
    trip      = (fail_next == FAIL_LIMIT);
    to_alarm  = trip && (lock_next == LOCK_LIMIT);
    tmr_load  = 1'b0;
    tmr_val   = '0;
    case (state)
      ARMED: begin
        if (!admin_clr) begin
          if (det_error) begin
            if (trip && !to_alarm) begin
              tmr_load = 1'b1;
              tmr_val  = LOCKOUT_LOAD;
            end
          end else if (det_unlock) begin
            tmr_load = 1'b1;
            tmr_val  = OPEN_LOAD;
          end
        end
      end
      LOCKOUT: begin
        if (admin_clr) begin
          tmr_load = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign tmr_en = (state == OPEN) || (state == LOCKOUT);
  assign det_in = key_in && (state == ARMED);

  door_timer #(
    .W(TMR_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // det_rst is gated by its own previous value so it can never stretch to two cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ARMED;
      fail_cnt  <= '0;
      lock_cnt  <= '0;
      det_rst   <= 1'b0;
      lock_open <= 1'b0;
      lockout   <= 1'b0;
      alarm     <= 1'b0;
    end else begin
      det_rst <= 1'b0;
      case (state)
        ARMED: begin
          if (admin_clr) begin
            fail_cnt <= '0;
            lock_cnt <= '0;
          end else if (det_error) begin
            det_rst <= ~det_rst;
            if (trip) begin
              fail_cnt <= '0;
              lock_cnt <= lock_next;
              lockout  <= 1'b1;
              if (to_alarm) begin
                state <= ALARM;
                alarm <= 1'b1;
              end else begin
                state <= LOCKOUT;
              end
            end else begin
              fail_cnt <= fail_next;
            end
          end else if (det_unlock) begin
            state     <= OPEN;
            lock_open <= 1'b1;
            fail_cnt  <= '0;
            lock_cnt  <= '0;
            det_rst   <= ~det_rst;
          end
        end
        OPEN: begin
          if (tmr_done) begin
            state     <= ARMED;
            lock_open <= 1'b0;
          end
        end
        LOCKOUT: begin
          if (admin_clr) begin
            state    <= ARMED;
            lockout  <= 1'b0;
            fail_cnt <= '0;
            lock_cnt <= '0;
          end else if (tmr_done) begin
            state   <= ARMED;
            lockout <= 1'b0;
          end
        end
        ALARM: begin
          if (admin_clr) begin
            state    <= ARMED;
            alarm    <= 1'b0;
            lockout  <= 1'b0;
            fail_cnt <= '0;
            lock_cnt <= '0;
            det_rst  <= ~det_rst;
          end
        end
        default: state <= ARMED;
      endcase
    end
  end

endmodule

// File: tb/tb_door_access_ctrl.sv
// Directed scoreboard bench for door_access_ctrl with short open/lockout periods.
module tb_door_access_ctrl;

  localparam int MF = 3;
  localparam int ML = 2;
  localparam int OC = 4;
  localparam int LC = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       key_in = 1'b0;
  logic       det_unlock = 1'b0;
  logic       det_error = 1'b0;
  logic       admin_clr = 1'b0;
  logic       det_in;
  logic       det_rst;
  logic       lock_open;
  logic       lockout;
  logic       alarm;
  logic [1:0] fail_cnt;

  typedef struct {
    string      tag;
    logic [6:0] vec;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  door_access_ctrl #(
    .MAX_FAILS      (MF),
    .MAX_LOCKOUTS   (ML),
    .OPEN_CYCLES    (OC),
    .LOCKOUT_CYCLES (LC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_in     (key_in),
    .det_unlock (det_unlock),
    .det_error  (det_error),
    .admin_clr  (admin_clr),
    .det_in     (det_in),
    .det_rst    (det_rst),
    .lock_open  (lock_open),
    .lockout    (lockout),
    .alarm      (alarm),
    .fail_cnt   (fail_cnt)
  );

  always #5 clk = ~clk;

  // Expected vector layout: {det_in, det_rst, lock_open, lockout, alarm, fail_cnt}.
  function automatic logic [6:0] v(input logic di, input logic dr, input logic lo,
                                   input logic lk, input logic al, input logic [1:0] fc);
    return {di, dr, lo, lk, al, fc};
  endfunction

  task automatic push_exp(input logic [6:0] exp, input string tag);
    exp_t e;
    e.tag = tag;
    e.vec = exp;
    sb.push_back(e);
  endtask

  task automatic apply_stimulus(input logic key, input logic unl, input logic err,
                                input logic clr, input logic [6:0] exp, input string tag);
    @(negedge clk);
    key_in     = key;
    det_unlock = unl;
    det_error  = err;
    admin_clr  = clr;
    push_exp(exp, tag);
  endtask

  task automatic check_output();
    exp_t       e;
    logic [6:0] obs;
    obs = {det_in, det_rst, lock_open, lockout, alarm, fail_cnt};
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_empty observed=%b expected=<entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.vec) else begin
        failures++;
        $error("[TB] FAIL %s observed=%b expected=%b", e.tag, obs, e.vec);
      end
    end
  endtask

  task automatic step(input logic key, input logic unl, input logic err, input logic clr,
                      input logic [6:0] exp, input string tag);
    apply_stimulus(key, unl, err, clr, exp, tag);
    @(posedge clk);
    #1;
    check_output();
  endtask

  initial begin
    logic rk;
    logic ru;
    logic re;

    // Reset held for two cycles with the keypad idle.
    repeat (2) @(posedge clk);
    #1;
    push_exp(v(0, 0, 0, 0, 0, 2'd0), "reset_state");
    check_output();
    @(negedge clk);
    reset = 1'b1;

    step(1, 0, 0, 0, v(1, 0, 0, 0, 0, 2'd0), "armed_key1");
    step(0, 0, 0, 0, v(0, 0, 0, 0, 0, 2'd0), "armed_key0");
    step(1, 0, 0, 0, v(1, 0, 0, 0, 0, 2'd0), "armed_key1b");

    // Unlock: door open for exactly OC cycles, detector outputs and admin_clr ignored.
    step(0, 1, 0, 0, v(0, 1, 1, 0, 0, 2'd0), "unlock_entry");
    step(1, 0, 0, 0, v(0, 0, 1, 0, 0, 2'd0), "open_c2");
    step(1, 1, 1, 0, v(0, 0, 1, 0, 0, 2'd0), "open_ignore_det");
    step(1, 0, 0, 1, v(0, 0, 1, 0, 0, 2'd0), "open_ignore_clr");
    step(1, 0, 0, 0, v(1, 0, 0, 0, 0, 2'd0), "open_exit");

    // First lockout after three failures.
    step(0, 0, 1, 0, v(0, 1, 0, 0, 0, 2'd1), "err1");
    step(0, 0, 0, 0, v(0, 0, 0, 0, 0, 2'd1), "gap1");
    step(0, 0, 1, 0, v(0, 1, 0, 0, 0, 2'd2), "err2");
    step(0, 0, 0, 0, v(0, 0, 0, 0, 0, 2'd2), "gap2");
    step(0, 0, 1, 0, v(0, 1, 0, 1, 0, 2'd0), "lockout_entry");
    for (int i = 0; i < LC - 1; i++) begin
      step(1, 0, (i == 2), 0, v(0, 0, 0, 1, 0, 2'd0), "lockout_hold");
    end
    step(0, 0, 0, 0, v(0, 0, 0, 0, 0, 2'd0), "lockout_exit");

    // Second lockout without an unlock escalates to a latched alarm.
    step(0, 0, 1, 0, v(0, 1, 0, 0, 0, 2'd1), "err1_b");
    step(0, 0, 0, 0, v(0, 0, 0, 0, 0, 2'd1), "gap1_b");
    step(0, 0, 1, 0, v(0, 1, 0, 0, 0, 2'd2), "err2_b");
    step(0, 0, 0, 0, v(0, 0, 0, 0, 0, 2'd2), "gap2_b");
    step(0, 0, 1, 0, v(0, 1, 0, 1, 1, 2'd0), "alarm_entry");
    for (int i = 0; i < 200; i++) begin
      rk = 1'($urandom_range(0, 1));
      ru = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      step(rk, ru, re, 0, v(0, 0, 0, 1, 1, 2'd0), "alarm_hold");
    end
    step(0, 0, 0, 1, v(0, 1, 0, 0, 0, 2'd0), "alarm_clear");
    step(0, 0, 0, 0, v(0, 0, 0, 0, 0, 2'd0), "after_clear");

    // Back-to-back errors never stretch det_rst; lock_cnt was cleared so this is a plain lockout.
    step(0, 0, 1, 0, v(0, 1, 0, 0, 0, 2'd1), "err_bb1");
    step(0, 0, 1, 0, v(0, 0, 0, 0, 0, 2'd2), "err_bb2_no_double_rst");
    step(0, 0, 0, 0, v(0, 0, 0, 0, 0, 2'd2), "gap_bb");
    step(0, 0, 1, 0, v(0, 1, 0, 1, 0, 2'd0), "lockout_after_clear");
    step(0, 0, 0, 0, v(0, 0, 0, 1, 0, 2'd0), "lockout_hold_b");
    step(0, 0, 0, 1, v(0, 0, 0, 0, 0, 2'd0), "lockout_admin_clr");

    // admin_clr in ARMED clears the fail count and swallows same-cycle events.
    step(0, 0, 1, 0, v(0, 1, 0, 0, 0, 2'd1), "err_pre_clr");
    step(0, 0, 0, 0, v(0, 0, 0, 0, 0, 2'd1), "gap_pre_clr");
    step(0, 0, 1, 1, v(0, 0, 0, 0, 0, 2'd0), "armed_clr_ignores_err");
    step(0, 1, 0, 1, v(0, 0, 0, 0, 0, 2'd0), "armed_clr_ignores_unlock");

    // Simultaneous unlock and error counts as a failure.
    step(0, 1, 1, 0, v(0, 1, 0, 0, 0, 2'd1), "unlock_and_error");
    step(0, 0, 0, 0, v(0, 0, 0, 0, 0, 2'd1), "gap_ue");
    step(0, 1, 0, 0, v(0, 1, 1, 0, 0, 2'd0), "unlock_clears_fail");
    step(1, 0, 0, 0, v(0, 0, 1, 0, 0, 2'd0), "open_before_rst");

    // Asynchronous reset between edges drops the door immediately.
    #2;
    key_in = 1'b0;
    reset  = 1'b0;
    #1;
    push_exp(v(0, 0, 0, 0, 0, 2'd0), "async_rst_drop");
    check_output();
    @(negedge clk);
    reset = 1'b1;
    step(1, 0, 0, 0, v(1, 0, 0, 0, 0, 2'd0), "armed_after_rst");
    step(0, 0, 1, 0, v(0, 1, 0, 0, 0, 2'd1), "err_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
